// File: rtl/ascon_bdi_sequencer_pkg.sv
// Shared encodings for the Ascon bdi sequencer:
// segment types, operation codes and FSM states.
package ascon_bdi_sequencer_pkg;

  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;
  localparam logic [3:0] D_HASH  = 4'h5;

  localparam logic [1:0] OP_ENC  = 2'd0;
  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_HASH = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    NONCE,
    AD,
    MSG,
    TAG
  } state_t;

  function automatic logic cmd_illegal(
    input logic [1:0] op,
    input logic       ad_zero
  );
    return (op == 2'd3) || (op == OP_HASH && ad_zero);
  endfunction

endpackage

// File: rtl/ascon_seg_counter.sv
// Loadable segment word counter.
// last is high on the final word of a non-empty segment.
module ascon_seg_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  assign last = (len != '0) && (cnt == len - LEN_W'(1));

endmodule

// File: rtl/ascon_bdi_sequencer.sv
// Host-side sequencer feeding key/bdi streams to the
// Ascon core in key, nonce, AD, PT/CT, tag order.
module ascon_bdi_sequencer
  import ascon_bdi_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_new_key,
  input  logic [LEN_W-1:0] cmd_ad_words,
  input  logic [LEN_W-1:0] cmd_msg_words,
  input  logic [31:0]      kin,
  input  logic             kin_valid,
  output logic             kin_ready,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [31:0]      key,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [31:0]      bdi,
  output logic             bdi_valid,
  input  logic             bdi_ready,
  output logic [3:0]       bdi_type,
  output logic             bdi_eot,
  output logic             bdi_eoi,
  output logic             decrypt,
  output logic             hash,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [LEN_W-1:0] BLK = LEN_W'(4);

  state_t           state;
  state_t           nxt;
  logic             dec_q;
  logic             hash_q;
  logic [LEN_W-1:0] ad_q;
  logic [LEN_W-1:0] msg_q;
  logic             done_q;
  logic             err_q;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] wcnt;
  logic             last;
  logic             in_bdi;
  logic             illegal;
  logic             accept;
  logic             xfer;
  logic             seg_end;
  logic             finish;

  assign illegal = cmd_illegal(cmd_op, cmd_ad_words == '0);
  assign accept  = (state == IDLE) && cmd_valid && !illegal;
  assign in_bdi  = (state == NONCE) || (state == AD) ||
                   (state == MSG) || (state == TAG);
  assign xfer    = (state == KEY) ? (kin_valid && key_ready)
                                  : (in_bdi && din_valid && bdi_ready);
  assign seg_end = xfer && last;

  always_comb begin
    len = '0;
    unique case (state)
      KEY, NONCE, TAG: len = BLK;
      AD:              len = ad_q;
      MSG:             len = msg_q;
      default:         len = '0;
    endcase
  end

  ascon_seg_counter #(
    .LEN_W (LEN_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || seg_end),
    .inc   (xfer),
    .len   (len),
    .cnt   (wcnt),
    .last  (last)
  );

  always_comb begin
    nxt      = state;
    finish   = 1'b0;
    bdi_type = D_NULL;
    bdi_eot  = 1'b0;
    bdi_eoi  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_HASH) nxt = AD;
          else if (cmd_new_key)  nxt = KEY;
          else                   nxt = NONCE;
        end
      end
      KEY: begin
        if (seg_end) nxt = NONCE;
      end
      NONCE: begin
        bdi_type = D_NONCE;
        bdi_eot  = last;
        bdi_eoi  = last && ad_q == '0 && msg_q == '0;
        if (seg_end) begin
          if (ad_q != '0)       nxt = AD;
          else if (msg_q != '0) nxt = MSG;
          else if (dec_q)       nxt = TAG;
          else                  finish = 1'b1;
        end
      end
      AD: begin
        bdi_type = D_AD;
        bdi_eot  = last;
        bdi_eoi  = last && (hash_q || msg_q == '0);
        if (seg_end) begin
          if (hash_q)           finish = 1'b1;
          else if (msg_q != '0) nxt = MSG;
          else if (dec_q)       nxt = TAG;
          else                  finish = 1'b1;
        end
      end
      MSG: begin
        bdi_type = D_PTCT;
        bdi_eot  = last;
        bdi_eoi  = last;
        if (seg_end) begin
          if (dec_q) nxt = TAG;
          else       finish = 1'b1;
        end
      end
      TAG: begin
        bdi_type = D_TAG;
        bdi_eot  = last;
        if (seg_end) finish = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (finish) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dec_q  <= 1'b0;
      hash_q <= 1'b0;
      ad_q   <= '0;
      msg_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= finish;
      err_q  <= (state == IDLE) && cmd_valid && illegal;
      if (accept) begin
        dec_q  <= (cmd_op == OP_DEC);
        hash_q <= (cmd_op == OP_HASH);
        ad_q   <= cmd_ad_words;
        msg_q  <= cmd_msg_words;
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign key       = kin;
  assign key_valid = (state == KEY) && kin_valid;
  assign kin_ready = (state == KEY) && key_ready;
  assign bdi       = din;
  assign bdi_valid = in_bdi && din_valid;
  assign din_ready = in_bdi && bdi_ready;
  assign decrypt   = dec_q;
  assign hash      = hash_q;
  assign done      = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ascon_bdi_sequencer.sv
// Randomized directed bench for ascon_bdi_sequencer
// against a queue-based segment model.
module tb_ascon_bdi_sequencer;
  import ascon_bdi_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_new_key;
  logic [7:0]  cmd_ad_words;
  logic [7:0]  cmd_msg_words;
  logic [31:0] kin;
  logic        kin_valid;
  logic        kin_ready;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] key;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] bdi;
  logic        bdi_valid;
  logic        bdi_ready;
  logic [3:0]  bdi_type;
  logic        bdi_eot;
  logic        bdi_eoi;
  logic        decrypt;
  logic        hash;
  logic        done;
  logic        cmd_err;

  always #5 clk = ~clk;

  ascon_bdi_sequencer #(.LEN_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_new_key   (cmd_new_key),
    .cmd_ad_words  (cmd_ad_words),
    .cmd_msg_words (cmd_msg_words),
    .kin           (kin),
    .kin_valid     (kin_valid),
    .kin_ready     (kin_ready),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .key           (key),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .bdi           (bdi),
    .bdi_valid     (bdi_valid),
    .bdi_ready     (bdi_ready),
    .bdi_type      (bdi_type),
    .bdi_eot       (bdi_eot),
    .bdi_eoi       (bdi_eoi),
    .decrypt       (decrypt),
    .hash          (hash),
    .done          (done),
    .cmd_err       (cmd_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic        eot;
    logic        eoi;
  } ent_t;

  ent_t        bq[$];
  logic [31:0] kq[$];
  int          npass = 0;
  int          ntot  = 0;
  logic        exp_dec = 1'b0;
  logic        exp_hash = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {cmd_ready, kin_ready, din_ready, key_valid, bdi_valid,
              bdi_type, bdi_eot, bdi_eoi, decrypt, hash, done, cmd_err},
        {1'b1, 4'b0000, D_NULL, 6'b000000});
  endtask

  // Expected transfer lists built straight from the segment rules
  function automatic void build(input logic [1:0] op, input logic nk,
                                input int ad, input int msg);
    ent_t e;
    bq.delete();
    kq.delete();
    if (op != OP_HASH) begin
      if (nk) for (int i = 0; i < 4; i++) kq.push_back($urandom);
      for (int i = 0; i < 4; i++) begin
        e = '{d: $urandom, t: D_NONCE, eot: (i == 3),
              eoi: (i == 3 && ad == 0 && msg == 0)};
        bq.push_back(e);
      end
    end
    for (int i = 0; i < ad; i++) begin
      e = '{d: $urandom, t: D_AD, eot: (i == ad - 1),
            eoi: (i == ad - 1 && (op == OP_HASH || msg == 0))};
      bq.push_back(e);
    end
    if (op != OP_HASH)
      for (int i = 0; i < msg; i++) begin
        e = '{d: $urandom, t: D_PTCT, eot: (i == msg - 1),
              eoi: (i == msg - 1)};
        bq.push_back(e);
      end
    if (op == OP_DEC)
      for (int i = 0; i < 4; i++) begin
        e = '{d: $urandom, t: D_TAG, eot: (i == 3), eoi: 1'b0};
        bq.push_back(e);
      end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic nk,
                        input int ad, input int msg,
                        input bit stall, input int abort_at);
    logic done_next;
    logic finished;
    logic kx;
    logic bx;
    int   nx;
    build(op, nk, ad, msg);
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_new_key   = nk;
    cmd_ad_words  = ad[7:0];
    cmd_msg_words = msg[7:0];
    #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
    exp_dec  = (op == OP_DEC);
    exp_hash = (op == OP_HASH);
    done_next = 1'b0;
    finished  = 1'b0;
    nx        = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      key_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bdi_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      kin_valid = (kq.size() > 0) && (!stall || $urandom_range(0, 2) != 0);
      din_valid = (bq.size() > 0) && (!stall || $urandom_range(0, 2) != 0);
      kin = (kq.size() > 0) ? kq[0] : $urandom;
      din = (bq.size() > 0) ? bq[0].d : $urandom;
      #1;
      chk("done", done, done_next);
      if (done_next) begin
        chk("cmd_ready_after_done", cmd_ready, 1'b1);
        finished = 1'b1;
        break;
      end
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("decrypt", decrypt, exp_dec);
      chk("hash", hash, exp_hash);
      chk("key_valid", key_valid, (kq.size() > 0) && kin_valid);
      chk("bdi_valid", bdi_valid,
          (kq.size() == 0) && (bq.size() > 0) && din_valid);
      kx = key_valid && key_ready;
      bx = bdi_valid && bdi_ready;
      if (key_valid && kq.size() > 0) begin
        chk("key", key, kq[0]);
        chk("kin_ready", kin_ready, key_ready);
      end
      if (bdi_valid && bq.size() > 0) begin
        chk("bdi", bdi, bq[0].d);
        chk("bdi_type", bdi_type, bq[0].t);
        chk("bdi_eot", bdi_eot, bq[0].eot);
        chk("bdi_eoi", bdi_eoi, bq[0].eoi);
        chk("din_ready", din_ready, bdi_ready);
      end
      if (kx && kq.size() > 0) void'(kq.pop_front());
      if (bx && bq.size() > 0) begin
        void'(bq.pop_front());
        nx++;
      end
      if ((kx || bx) && kq.size() == 0 && bq.size() == 0)
        done_next = 1'b1;
      if (abort_at >= 0 && nx == abort_at) begin
        @(negedge clk);
        kin_valid = 1'b0;
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_mid_op");
        @(negedge clk);
        chk_reset_vals("reset_held");
        rst_n    = 1'b1;
        exp_dec  = 1'b0;
        exp_hash = 1'b0;
        return;
      end
    end
    chk("op_finished", finished, 1'b1);
    kin_valid = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic bad_cmd(input logic [1:0] op, input int ad);
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_new_key   = 1'b1;
    cmd_ad_words  = ad[7:0];
    cmd_msg_words = 8'd2;
    din_valid     = 1'b1;
    kin_valid     = 1'b1;
    #1 chk("bad_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cmd_err_pulse", cmd_err, 1'b1);
    chk("bad_ready_stays", cmd_ready, 1'b1);
    chk("bad_no_bdi", bdi_valid, 1'b0);
    chk("bad_no_key", key_valid, 1'b0);
    chk("bad_flags", {decrypt, hash}, {exp_dec, exp_hash});
    @(negedge clk);
    #1;
    chk("cmd_err_drop", cmd_err, 1'b0);
    chk("bad_no_bdi2", bdi_valid, 1'b0);
    din_valid = 1'b0;
    kin_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_op        = OP_ENC;
    cmd_new_key   = 1'b0;
    cmd_ad_words  = '0;
    cmd_msg_words = '0;
    kin           = '0;
    kin_valid     = 1'b0;
    din           = '0;
    din_valid     = 1'b0;
    key_ready     = 1'b1;
    bdi_ready     = 1'b1;
    #12 chk_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_ENC, 1'b1, 2, 3, 1'b0, -1);
    run_op(OP_DEC, 1'b0, 0, 0, 1'b0, -1);
    run_op(OP_HASH, 1'b0, 5, 0, 1'b0, -1);
    bad_cmd(OP_HASH, 0);
    bad_cmd(2'd3, 2);
    for (int i = 0; i < 4; i++) run_op(OP_ENC, 1'b0, 1, 1, 1'b1, -1);
    for (int i = 0; i < 4; i++)
      run_op(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 6), $urandom_range(0, 6), 1'b1, -1);
    run_op(OP_DEC, 1'b1, 0, 3, 1'b1, -1);
    run_op(OP_ENC, 1'b0, 0, 3, 1'b0, 5);
    run_op(OP_ENC, 1'b1, 1, 2, 1'b0, -1);
    run_op(OP_DEC, 1'b0, 3, 0, 1'b1, -1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
